pipelined_adder: RTL
====================

PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand/sum width in bits.
REQ-002 The block SHALL have parameter LANE, default 8, meaning bits added per pipeline stage; STAGES = WIDTH/LANE.
REQ-003 The block SHALL have port clk  input  1  rising-edge clock; one clock domain only.
REQ-004 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port in_valid  input  1  operand set present.
REQ-006 The block SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-007 The block SHALL have port a  input  WIDTH  first operand.
REQ-008 The block SHALL have port b  input  WIDTH  second operand.
REQ-009 The block SHALL have port carry_in  input  1  carry (add) or borrow-complement input (sub).
REQ-010 The block SHALL have port sub  input  1  mode: 0 add, 1 subtract.
REQ-011 The block SHALL have port out_valid  output  1  result present.
REQ-012 The block SHALL have port out_ready  input  1  consumer accepts result.
REQ-013 The block SHALL have port sum  output  WIDTH  result.
REQ-014 The block SHALL have port carry_out  output  1  carry out of MSB (sub: 1 = no borrow).
REQ-015 The block SHALL have port overflow  output  1  two's-complement signed overflow.

Function
REQ-016 Elaboration SHALL fail if WIDTH is not a nonzero multiple of LANE, or LANE < 1.
REQ-017 Add mode SHALL produce {carry_out, sum} = a + b + carry_in, modulo 2^(WIDTH+1).
REQ-018 Sub mode SHALL produce {carry_out, sum} = a + ~b + carry_in; carry_in=1 gives a-b, carry_in=0 gives a-b-1.
REQ-019 overflow SHALL be 1 when the effective operand MSBs (a, b or ~b) are equal and sum MSB differs from them.
REQ-020 Stage k (0..STAGES-1) SHALL add lane k bits [k*LANE +: LANE] using the registered carry from stage k-1; stage 0 uses carry_in.
REQ-021 Unprocessed upper lanes and finished lower lanes SHALL travel with each operation through the pipeline registers.
REQ-022 A transfer in SHALL occur when in_valid && in_ready; a transfer out when out_valid && out_ready.
REQ-023 Latency SHALL be exactly STAGES cycles from the input-transfer edge to out_valid high, absent stalls.
REQ-024 Throughput SHALL be one operation per cycle when out_ready is held high.
REQ-025 Stall: when out_valid && !out_ready, the whole pipeline SHALL hold and in_ready SHALL be 0.
REQ-026 Otherwise in_ready SHALL be 1; it SHALL depend combinationally only on out_valid and out_ready.
REQ-027 Held sum, carry_out and overflow SHALL remain stable while out_valid && !out_ready.
REQ-028 Each stage SHALL carry a valid bit; bubbles (in_valid=0) SHALL propagate as out_valid=0 without corrupting neighbours.
REQ-029 Operations SHALL emerge in acceptance order, with no loss or duplication.
REQ-030 Input transfer and output transfer in the same cycle SHALL both complete.
REQ-031 a, b, carry_in and sub SHALL be sampled only on the input-transfer edge; later changes SHALL not affect that operation.

Reset
REQ-032 While rst=1 at a clk edge, every stage valid bit SHALL clear, giving out_valid=0 the next cycle.
REQ-033 After reset, sum, carry_out and overflow SHALL read 0 until the first result.
REQ-034 Reset mid-operation SHALL discard all in-flight operations; none SHALL appear after rst deasserts.
REQ-035 in_ready SHALL be 1 in the first cycle after rst deasserts.

Verification (WIDTH=32, LANE=8, latency 4)
REQ-036 Bench: add 0xFFFFFFFF + 0x00000001, cin=0 -> 4 cycles later sum=0x00000000, carry_out=1, overflow=0.
REQ-037 Bench: add 0x7FFFFFFF + 0x00000001, cin=0 -> sum=0x80000000, carry_out=0, overflow=1; add 0x000000FF + 0x00000001, cin=1 -> sum=0x00000101 (carry crosses lane boundary).
REQ-038 Bench: sub 5 - 3, cin=1 -> sum=0x00000002, carry_out=1; sub 3 - 5, cin=1 -> sum=0xFFFFFFFE, carry_out=0; sub 0x80000000 - 1, cin=1 -> 0x7FFFFFFF, overflow=1.
REQ-039 Bench: 8 back-to-back adds, out_ready=1 -> 8 consecutive out_valid cycles, correct values in order.
REQ-040 Bench: out_ready=0 for 5 cycles while results pending -> in_ready=0, output held stable, no loss after release.
REQ-041 Bench: rst pulsed 2 cycles after accepting 2 operations -> out_valid stays 0, sum=0 afterward.

Source files
------------

// File: rtl/pipelined_adder.sv
// Pipelined adder/subtractor that resolves LANE bits of the carry chain per
// stage. It uses a valid/ready handshake, and a stall at the output holds
// the whole pipeline.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operand set present
//   in_ready   block accepts operands this cycle (combinational from output stage)
//   a, b       operands, WIDTH bits
//   carry_in   carry (add) or borrow-complement (sub) input
//   sub        0 = add, 1 = subtract (a + ~b + carry_in)
//   out_valid  result present
//   out_ready  consumer accepts result
//   sum        result, WIDTH bits
//   carry_out  carry out of MSB (sub: 1 = no borrow)
//   overflow   two's-complement signed overflow
module pipelined_adder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LANE  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int unsigned LANE_SAFE = (LANE == 0) ? 1 : LANE;
  localparam int unsigned STAGES    = (WIDTH / LANE_SAFE == 0) ? 1 : WIDTH / LANE_SAFE;
  localparam int unsigned LW        = LANE_SAFE + 1;

  // Reject geometries that cannot be split into whole lanes.
  generate
    if ((LANE < 1) || (WIDTH == 0) || ((WIDTH % LANE_SAFE) != 0)) begin : g_bad_param
      $error("pipelined_adder: WIDTH must be a nonzero multiple of LANE, LANE >= 1");
    end
  endgenerate

  // Register index 0 captures the operands; index s (1..STAGES) holds the
  // operation after lanes 0..s-1 have been summed.
  logic             r_v [0:STAGES];
  logic [WIDTH-1:0] r_a [0:STAGES-1];
  logic [WIDTH-1:0] r_b [0:STAGES-1];
  logic [WIDTH-1:0] r_s [0:STAGES];
  logic             r_c [0:STAGES];
  logic             r_ovf;

  logic [WIDTH-1:0] w_s_nxt [1:STAGES];
  logic             w_c_nxt [1:STAGES];
  logic             w_ovf_nxt;
  logic             w_adv;

  // Pipeline moves unless a finished result is waiting on the consumer.
  assign w_adv    = !(r_v[STAGES] && !out_ready);
  assign in_ready = w_adv;

  // Per-stage lane add: one LANE-bit slice plus the carry from the stage before.
  always_comb begin
    logic [LANE_SAFE:0] v_lane;
    v_lane = '0;
    for (int s = 1; s <= int'(STAGES); s++) begin
      v_lane = {1'b0, r_a[s-1][(s-1)*LANE_SAFE +: LANE_SAFE]}
             + {1'b0, r_b[s-1][(s-1)*LANE_SAFE +: LANE_SAFE]}
             + LW'(r_c[s-1]);
      w_s_nxt[s] = r_s[s-1];
      w_s_nxt[s][(s-1)*LANE_SAFE +: LANE_SAFE] = v_lane[LANE_SAFE-1:0];
      w_c_nxt[s] = v_lane[LANE_SAFE];
    end
  end

  // Signed overflow: operand MSBs agree but the result MSB does not.
  assign w_ovf_nxt = (r_a[STAGES-1][WIDTH-1] == r_b[STAGES-1][WIDTH-1]) &&
                     (w_s_nxt[STAGES][WIDTH-1] != r_a[STAGES-1][WIDTH-1]);

  // Pipeline registers; data only moves alongside a valid bit so bubbles
  // leave the held results untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s <= int'(STAGES); s++) begin
        r_v[s] <= 1'b0;
        r_s[s] <= '0;
        r_c[s] <= 1'b0;
      end
      for (int s = 0; s < int'(STAGES); s++) begin
        r_a[s] <= '0;
        r_b[s] <= '0;
      end
      r_ovf <= 1'b0;
    end else if (w_adv) begin
      r_v[0] <= in_valid;
      if (in_valid) begin
        r_a[0] <= a;
        r_b[0] <= sub ? ~b : b;
        r_c[0] <= carry_in;
        r_s[0] <= '0;
      end
      for (int s = 1; s <= int'(STAGES); s++) begin
        r_v[s] <= r_v[s-1];
        if (r_v[s-1]) begin
          r_s[s] <= w_s_nxt[s];
          r_c[s] <= w_c_nxt[s];
        end
      end
      for (int s = 1; s < int'(STAGES); s++) begin
        if (r_v[s-1]) begin
          r_a[s] <= r_a[s-1];
          r_b[s] <= r_b[s-1];
        end
      end
      if (r_v[STAGES-1]) begin
        r_ovf <= w_ovf_nxt;
      end
    end
  end

  assign out_valid = r_v[STAGES];
  assign sum       = r_s[STAGES];
  assign carry_out = r_c[STAGES];
  assign overflow  = r_ovf;

endmodule
